// File: rtl/cic_decim_ctrl_if.sv
// Handshake and datapath-control bundle between the CIC sequencing controller,
// the sample source, the integrator/comb datapath and the downstream consumer.
interface cic_decim_ctrl_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] filt_out;
  logic             filt_clr;
  logic             integ_en;
  logic             comb_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             overrun;

  // Controller side
  modport slave (
    input  en, in_valid, filt_out, out_ready,
    output in_ready, filt_clr, integ_en, comb_en, out_valid, out_data, overrun
  );

  // Source / datapath / consumer side
  modport master (
    output en, in_valid, filt_out, out_ready,
    input  in_ready, filt_clr, integ_en, comb_en, out_valid, out_data, overrun
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencing controller: integrator/comb enables, clear pulse,
// start-up discard and a one-entry output register. Optional: CIC_CTRL_SETTLE_EN.
module cic_decim_ctrl #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1,
  parameter int RATE   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  cic_decim_ctrl_if.slave  bus
);

  localparam int              PW   = $clog2(RATE);
  localparam logic [PW-1:0]   LAST = PW'(RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PW-1:0]    r_phase;
  logic             r_cap_pend;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_overrun;

  logic w_active;
  logic w_last;
  logic w_in_ready;
  logic w_accept;
  logic w_comb;
  logic w_drop_done;

  assign w_active = (r_state == S_SETTLE) || (r_state == S_RUN);
  assign w_last   = (r_phase == LAST);
  // Stall the last sample of a frame whenever its result would have nowhere to go.
  assign w_in_ready = w_active && !(w_last && (r_cap_pend || (r_out_valid && !bus.out_ready)));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_comb     = w_accept && w_last;

`ifdef CIC_CTRL_SETTLE_EN
  localparam int SW = $clog2(STAGES + 1);
  logic [SW-1:0] r_settle_cnt;

  assign w_drop_done = (r_state == S_SETTLE) && r_cap_pend && (r_settle_cnt == SW'(STAGES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_settle_cnt <= '0;
    end else if (!bus.en || (r_state != S_SETTLE)) begin
      r_settle_cnt <= '0;
    end else if (r_cap_pend) begin
      r_settle_cnt <= r_settle_cnt + 1'b1;
    end
  end
`else
  assign w_drop_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!bus.en) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_next = S_CLEAR;
`ifdef CIC_CTRL_SETTLE_EN
        S_CLEAR:  w_state_next = S_SETTLE;
`else
        S_CLEAR:  w_state_next = S_RUN;
`endif
        S_SETTLE: if (w_drop_done) w_state_next = S_RUN;
        default:  w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase    <= '0;
      r_cap_pend <= 1'b0;
    end else if (!bus.en || !w_active) begin
      r_phase    <= '0;
      r_cap_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_phase <= r_phase + 1'b1;
      end
      r_cap_pend <= w_comb;
    end
  end

  // Captures taken while settling are dropped; only RUN captures reach the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (!bus.en || !w_active) begin
      r_out_valid <= 1'b0;
    end else if (r_cap_pend && (r_state == S_RUN)) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.filt_out;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overrun <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.en) begin
      r_overrun <= 1'b0;
    end else if (w_active && bus.in_valid && !w_in_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.filt_clr  = (r_state == S_CLEAR);
  assign bus.integ_en  = w_accept;
  assign bus.comb_en   = w_comb;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.overrun   = r_overrun;

endmodule
